// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
// Shared definitions for the core sequencer: FSM state encoding, PC-select
// codes, the default bus timeout and the write-back PC-select helper.
// ---------------------------------------------------------------------------
package core_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_ERR    = 3'd6
  } state_e;

  localparam logic [1:0] PC_SEL_SEQ  = 2'b00;  // PC + 4
  localparam logic [1:0] PC_SEL_BR   = 2'b01;  // branch / JAL target
  localparam logic [1:0] PC_SEL_JALR = 2'b10;  // JALR target

  localparam int TIMEOUT_DEFAULT = 15;

  // JALR has priority over JAL and taken branches; anything else falls
  // through to the sequential PC.
  function automatic logic [1:0] wb_pc_sel(input logic       jal,
                                           input logic       jalr,
                                           input logic [2:0] branch_cntr,
                                           input logic       br_taken);
    logic [1:0] sel;
    sel = PC_SEL_SEQ;
    if (jalr) begin
      sel = PC_SEL_JALR;
    end else if (jal || ((branch_cntr != 3'd0) && br_taken)) begin
      sel = PC_SEL_BR;
    end
    return sel;
  endfunction

endpackage

// File: rtl/bus_timer.sv
// ---------------------------------------------------------------------------
// bus_timer
// Counts cycles in which a bus request is outstanding without an ack and
// flags the cycle in which the TIMEOUT-th such cycle occurs.
//
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset
//   start    in   clear the count (asserted on the edge entering a bus phase)
//   req      in   request currently high
//   ack      in   acknowledge this cycle
//   expired  out  this cycle is the TIMEOUT-th consecutive un-acked cycle
// ---------------------------------------------------------------------------
module bus_timer
  import core_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic req,
  input  logic ack,
  output logic expired
);

  localparam int             CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  LIMIT    = CW'(TIMEOUT);
  localparam logic [CW-1:0]  LIMIT_M1 = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q holds the number of un-acked cycles already seen; the current
  // cycle is the TIMEOUT-th one when cnt_q has reached TIMEOUT-1. An ack in
  // that same cycle masks the expiry.
  assign expired = req && !ack && (cnt_q >= LIMIT_M1);

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (req && !ack && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/core_seq.sv
// ---------------------------------------------------------------------------
// core_seq
// Multi-cycle instruction sequencer: fetch, decode, execute, optional data
// memory access, write-back, with a per-access bus timeout that parks the
// core in a sticky error state.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   halt_req                 stop at the next retire boundary
//   imem_ack, dmem_ack       instruction / data bus acknowledges
//   is_load, is_store        decoded access type
//   reg_write                decoded register-file write enable
//   branch_cntr[2:0]         decoded branch code (0 = not a branch)
//   jal, jalr, br_taken      jump flags and branch comparator result
//   imem_req                 instruction fetch request
//   dmem_req, dmem_we        data request and write qualifier
//   ir_we                    instruction register load strobe
//   hold                     decoder hold
//   rf_we, pc_we             register-file / PC write strobes
//   pc_sel[1:0]              next-PC source
//   halted, bus_err          status flags
//   retire_cnt[31:0]         retired-instruction counter
// ---------------------------------------------------------------------------
module core_seq
  import core_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt_req,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        reg_write,
  input  logic [2:0]  branch_cntr,
  input  logic        jal,
  input  logic        jalr,
  input  logic        br_taken,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        ir_we,
  output logic        hold,
  output logic        rf_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        halted,
  output logic        bus_err,
  output logic [31:0] retire_cnt
);

  state_e      state_q, state_d;
  logic [31:0] retire_cnt_q, retire_cnt_d;
  logic        retire;
  logic        bus_req;
  logic        bus_ack;
  logic        timer_start;
  logic        timer_expired;

  // Only one bus phase is active at a time, so one timer serves both.
  assign bus_req = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign bus_ack = (state_q == ST_FETCH) ? imem_ack : dmem_ack;

  // Clear on every entry into a bus phase, including the direct
  // MEM -> FETCH hop after a store.
  assign timer_start = (state_d != state_q) &&
                       ((state_d == ST_FETCH) || (state_d == ST_MEM));

  bus_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_bus_timer (
    .clk     (clk),
    .rst     (rst),
    .start   (timer_start),
    .req     (bus_req),
    .ack     (bus_ack),
    .expired (timer_expired)
  );

  always_comb begin
    state_d  = state_q;
    retire   = 1'b0;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    ir_we    = 1'b0;
    hold     = 1'b0;
    rf_we    = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = PC_SEL_SEQ;
    halted   = 1'b0;
    bus_err  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        halted = 1'b1;
        hold   = 1'b1;
        if (!halt_req) begin
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: begin
        imem_req = 1'b1;
        hold     = 1'b1;
        if (imem_ack) begin
          ir_we   = 1'b1;
          state_d = ST_DECODE;
        end else if (timer_expired) begin
          state_d = ST_ERR;
        end
      end

      ST_DECODE: begin
        state_d = ST_EXEC;
      end

      ST_EXEC: begin
        state_d = (is_load || is_store) ? ST_MEM : ST_WB;
      end

      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (dmem_ack) begin
          if (is_store) begin
            // Stores retire straight out of MEM; no register write.
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = halt_req ? ST_IDLE : ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (timer_expired) begin
          state_d = ST_ERR;
        end
      end

      ST_WB: begin
        rf_we   = reg_write;
        pc_we   = 1'b1;
        pc_sel  = wb_pc_sel(jal, jalr, branch_cntr, br_taken);
        retire  = 1'b1;
        state_d = halt_req ? ST_IDLE : ST_FETCH;
      end

      ST_ERR: begin
        bus_err = 1'b1;
        hold    = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Keep every request and strobe quiet while reset is held, whatever
    // state the register happens to be in.
    if (rst) begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      ir_we    = 1'b0;
      rf_we    = 1'b0;
      pc_we    = 1'b0;
      pc_sel   = PC_SEL_SEQ;
      bus_err  = 1'b0;
      hold     = 1'b1;
      halted   = 1'b1;
    end
  end

  assign retire_cnt_d = retire ? (retire_cnt_q + 32'd1) : retire_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      retire_cnt_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_core_seq.sv
// ---------------------------------------------------------------------------
// tb_core_seq
// Directed scenarios followed by randomized traffic, each cycle compared
// against a phase-level reference model of the sequencer.
// ---------------------------------------------------------------------------
module tb_core_seq;

  localparam int TIMEOUT = 15;

  logic        clk;
  logic        rst;
  logic        halt_req;
  logic        imem_ack;
  logic        dmem_ack;
  logic        is_load;
  logic        is_store;
  logic        reg_write;
  logic [2:0]  branch_cntr;
  logic        jal;
  logic        jalr;
  logic        br_taken;
  logic        imem_req;
  logic        dmem_req;
  logic        dmem_we;
  logic        ir_we;
  logic        hold;
  logic        rf_we;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic        halted;
  logic        bus_err;
  logic [31:0] retire_cnt;

  core_seq #(
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .halt_req    (halt_req),
    .imem_ack    (imem_ack),
    .dmem_ack    (dmem_ack),
    .is_load     (is_load),
    .is_store    (is_store),
    .reg_write   (reg_write),
    .branch_cntr (branch_cntr),
    .jal         (jal),
    .jalr        (jalr),
    .br_taken    (br_taken),
    .imem_req    (imem_req),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .ir_we       (ir_we),
    .hold        (hold),
    .rf_we       (rf_we),
    .pc_we       (pc_we),
    .pc_sel      (pc_sel),
    .halted      (halted),
    .bus_err     (bus_err),
    .retire_cnt  (retire_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: which phase the instruction is in, how many un-acked
  // bus cycles have elapsed in the current phase, and the retire count.
  typedef enum int {M_IDLE, M_FETCH, M_DECODE, M_EXEC, M_MEM, M_WB, M_ERR} mphase_t;

  mphase_t     m_phase;
  int          m_wait;
  logic [31:0] m_retire;
  bit          m_retired;

  int n_checks = 0;
  int n_fail   = 0;

  // Stimulus plan: acks arrive after plan_fw / plan_mw idle bus cycles.
  int plan_fw     = 0;
  int plan_mw     = 0;
  bit halt_in_mem = 0;
  bit rand_mode   = 0;

  // Observed-activity tallies for the directed scenarios.
  int         g_active, g_dreq, g_dwe, g_irwe, g_rfwe, g_pcwe, g_berr;
  logic [1:0] g_sel;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_tally();
    g_active = 0; g_dreq = 0; g_dwe = 0; g_irwe = 0;
    g_rfwe = 0; g_pcwe = 0; g_berr = 0; g_sel = 2'b11;
  endtask

  function automatic int pick_plan();
    return ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 18))
                                       : int'($urandom_range(0, 3));
  endfunction

  // One clock cycle: finish driving inputs, check outputs against the model
  // just before the edge, then advance the model across the edge.
  task automatic cyc();
    bit         e_imem, e_dreq, e_dwe, e_irwe, e_hold, e_rfwe, e_pcwe, e_halted, e_berr;
    bit [1:0]   e_sel;
    logic [10:0] exp_v, obs_v;
    mphase_t    nxt;

    imem_ack = (m_phase == M_FETCH) && (m_wait >= plan_fw);
    dmem_ack = (m_phase == M_MEM) && (m_wait >= plan_mw);
    if (rand_mode) begin
      // Acks outside the matching request phase must be ignored.
      if (m_phase != M_FETCH && $urandom_range(0, 3) == 0) imem_ack = 1'b1;
      if (m_phase != M_MEM   && $urandom_range(0, 3) == 0) dmem_ack = 1'b1;
    end
    if (halt_in_mem && m_phase == M_MEM) halt_req = 1'b1;
    #1;

    e_imem = 0; e_dreq = 0; e_dwe = 0; e_irwe = 0; e_hold = 0;
    e_rfwe = 0; e_pcwe = 0; e_halted = 0; e_berr = 0; e_sel = 2'b00;
    if (rst) begin
      e_hold = 1; e_halted = 1;
    end else begin
      case (m_phase)
        M_IDLE:  begin e_hold = 1; e_halted = 1; end
        M_FETCH: begin e_imem = 1; e_hold = 1; e_irwe = imem_ack; end
        M_MEM: begin
          e_dreq = 1;
          e_dwe  = is_store;
          e_pcwe = dmem_ack && is_store;
        end
        M_WB: begin
          e_rfwe = reg_write;
          e_pcwe = 1;
          if (jalr) e_sel = 2'b10;
          else if (jal || (branch_cntr != 0 && br_taken)) e_sel = 2'b01;
          else e_sel = 2'b00;
        end
        M_ERR:   begin e_berr = 1; e_hold = 1; end
        default: begin end
      endcase
    end

    exp_v = {e_imem, e_dreq, e_dwe, e_irwe, e_hold, e_rfwe, e_pcwe, e_sel, e_halted, e_berr};
    obs_v = {imem_req, dmem_req, dmem_we, ir_we, hold, rf_we, pc_we, pc_sel, halted, bus_err};
    chk($sformatf("outputs@%s", m_phase.name()), 32'(obs_v), 32'(exp_v));
    chk("retire_cnt", retire_cnt, m_retire);

    if (m_phase != M_IDLE) g_active++;
    if (dmem_req) g_dreq++;
    if (dmem_we)  g_dwe++;
    if (ir_we)    g_irwe++;
    if (rf_we)    g_rfwe++;
    if (bus_err)  g_berr++;
    if (pc_we) begin g_pcwe++; g_sel = pc_sel; end

    m_retired = 0;
    nxt = m_phase;
    if (rst) begin
      nxt = M_IDLE;
      m_retire = 0;
    end else begin
      case (m_phase)
        M_IDLE:   nxt = halt_req ? M_IDLE : M_FETCH;
        M_FETCH:  if (imem_ack) nxt = M_DECODE;
                  else if (m_wait + 1 == TIMEOUT) nxt = M_ERR;
        M_DECODE: nxt = M_EXEC;
        M_EXEC:   nxt = (is_load || is_store) ? M_MEM : M_WB;
        M_MEM: begin
          if (dmem_ack) begin
            if (is_store) begin
              m_retire++; m_retired = 1;
              nxt = halt_req ? M_IDLE : M_FETCH;
            end else begin
              nxt = M_WB;
            end
          end else if (m_wait + 1 == TIMEOUT) begin
            nxt = M_ERR;
          end
        end
        M_WB: begin
          m_retire++; m_retired = 1;
          nxt = halt_req ? M_IDLE : M_FETCH;
        end
        default: nxt = m_phase;
      endcase
    end

    if (rst || nxt != m_phase) m_wait = 0;
    else if (m_phase == M_FETCH || m_phase == M_MEM) m_wait++;

    if (rand_mode && nxt != m_phase) begin
      if (nxt == M_FETCH) plan_fw = pick_plan();
      if (nxt == M_MEM)   plan_mw = pick_plan();
    end
    m_phase = nxt;

    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input bit ld, input bit st, input bit rw, input logic [2:0] bc,
                         input bit j, input bit jr, input bit bt);
    is_load = ld; is_store = st; reg_write = rw; branch_cntr = bc;
    jal = j; jalr = jr; br_taken = bt;
  endtask

  // Run until the model retires an instruction or lands in ERR.
  task automatic run_instr(input string tag);
    int n;
    n = 0;
    clr_tally();
    do begin
      cyc();
      n++;
    end while (!m_retired && m_phase != M_ERR && n < 80);
    chk({tag, "_bound"}, 32'(n < 80), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int errs;
    rst = 1'b1; halt_req = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    set_dec(0, 0, 0, 3'd0, 0, 0, 0);
    m_phase = M_IDLE; m_wait = 0; m_retire = 0; m_retired = 0;
    @(posedge clk);
    #1;

    // Held reset.
    cyc();
    cyc();
    chk("reset_retire", retire_cnt, 32'd0);
    chk("reset_halted", 32'(halted), 32'd1);
    rst = 1'b0;

    // ALU op, fetch acked one cycle after request.
    set_dec(0, 0, 1, 3'd0, 0, 0, 0);
    plan_fw = 1;
    run_instr("alu");
    chk("alu_cycles", g_active, 5);
    chk("alu_irwe", g_irwe, 1);
    chk("alu_rfwe", g_rfwe, 1);
    chk("alu_sel", 32'(g_sel), 32'd0);
    chk("alu_retire", retire_cnt, 32'd1);

    // Load with data ack delayed three cycles.
    set_dec(1, 0, 1, 3'd0, 0, 0, 0);
    plan_fw = 0; plan_mw = 3;
    run_instr("load");
    chk("load_dreq", g_dreq, 4);
    chk("load_dwe", g_dwe, 0);
    chk("load_rfwe", g_rfwe, 1);
    chk("load_retire", retire_cnt, 32'd2);

    // Store: reg_write from the decoder must not leak to rf_we.
    set_dec(0, 1, 1, 3'd0, 0, 0, 0);
    plan_mw = 0;
    run_instr("store");
    chk("store_dwe", g_dwe, 1);
    chk("store_pcwe", g_pcwe, 1);
    chk("store_rfwe", g_rfwe, 0);
    chk("store_next_fetch", 32'(imem_req), 32'd1);
    chk("store_retire", retire_cnt, 32'd3);

    // PC-select variants.
    set_dec(0, 0, 0, 3'b001, 0, 0, 1);
    run_instr("br_taken");
    chk("br_taken_sel", 32'(g_sel), 32'd1);
    set_dec(0, 0, 1, 3'd0, 0, 1, 0);
    run_instr("jalr");
    chk("jalr_sel", 32'(g_sel), 32'd2);
    set_dec(0, 0, 0, 3'b001, 0, 0, 0);
    run_instr("br_not_taken");
    chk("br_not_taken_sel", 32'(g_sel), 32'd0);
    set_dec(0, 0, 1, 3'd0, 1, 0, 0);
    run_instr("jal");
    chk("jal_sel", 32'(g_sel), 32'd1);

    // Fetch ack withheld: error after exactly TIMEOUT request cycles, sticky.
    set_dec(0, 0, 1, 3'd0, 0, 0, 0);
    plan_fw = 99;
    run_instr("fetch_timeout");
    chk("fetch_timeout_cycles", g_active, TIMEOUT);
    chk("fetch_timeout_err", 32'(bus_err), 32'd1);
    for (int i = 0; i < 4; i++) cyc();
    chk("err_sticky", 32'(bus_err), 32'd1);
    chk("err_sticky_retire", retire_cnt, 32'd7);
    do_reset();
    chk("err_cleared", 32'(bus_err), 32'd0);
    chk("err_cleared_retire", retire_cnt, 32'd0);

    // Ack on exactly the TIMEOUT-th cycle wins.
    plan_fw = TIMEOUT - 1;
    run_instr("ack_at_limit");
    chk("ack_at_limit_cycles", g_active, TIMEOUT + 3);
    chk("ack_at_limit_berr", g_berr, 0);
    chk("ack_at_limit_retire", retire_cnt, 32'd1);

    // Data-side timeout.
    set_dec(1, 0, 1, 3'd0, 0, 0, 0);
    plan_fw = 0; plan_mw = 99;
    run_instr("mem_timeout");
    chk("mem_timeout_dreq", g_dreq, TIMEOUT);
    chk("mem_timeout_err", 32'(bus_err), 32'd1);
    do_reset();

    // Halt raised mid-MEM: instruction completes, then IDLE.
    plan_mw = 2;
    halt_in_mem = 1;
    run_instr("halt_mid_mem");
    chk("halt_retire", retire_cnt, 32'd1);
    chk("halt_halted", 32'(halted), 32'd1);
    cyc();
    cyc();
    chk("halt_stays", 32'(halted), 32'd1);
    chk("halt_no_fetch", 32'(imem_req), 32'd0);
    halt_in_mem = 0;
    halt_req = 1'b0;

    // Reset mid-MEM.
    plan_mw = 50;
    for (int i = 0; i < 40 && m_phase != M_MEM; i++) cyc();
    cyc();
    cyc();
    chk("rst_mid_mem_dreq", 32'(dmem_req), 32'd1);
    rst = 1'b1;
    cyc();
    chk("rst_mid_mem_retire", retire_cnt, 32'd0);
    chk("rst_mid_mem_halted", 32'(halted), 32'd1);
    chk("rst_mid_mem_dreq_off", 32'(dmem_req), 32'd0);
    rst = 1'b0;

    // Randomized traffic.
    rand_mode = 1;
    plan_fw = pick_plan();
    plan_mw = pick_plan();
    errs = 0;
    for (int i = 0; i < 3000; i++) begin
      if (m_phase == M_IDLE || m_phase == M_FETCH) begin
        case ($urandom_range(0, 2))
          0:       set_dec(0, 0, 1'($urandom), 3'($urandom), 1'($urandom_range(0, 3) == 0),
                           1'($urandom_range(0, 3) == 0), 1'($urandom));
          1:       set_dec(1, 0, 1'($urandom), 3'd0, 0, 0, 0);
          default: set_dec(0, 1, 1'($urandom), 3'd0, 0, 0, 0);
        endcase
      end
      halt_req = ($urandom_range(0, 15) == 0);
      errs = (m_phase == M_ERR) ? errs + 1 : 0;
      rst = ($urandom_range(0, 299) == 0) || (errs > 3);
      cyc();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
